move_check_sequencer: RTL and testbench

- Front end of the board validator: accepts one move request, decodes the source piece from the board, and rejects trivially illegal moves itself.
- Legal candidates go to exactly one per-piece checker (pawn, knight, bishop, rook, queen, king) with a one-cycle start pulse; the sequencer then waits for that checker's done, with a timeout.
- Returns a single registered verdict plus error code to the game-play FSM over a valid/ready handshake.

---
 rtl/move_check_sequencer_if.sv | 41 ++++
 rtl/move_check_sequencer.sv | 165 ++++++++++++++++
 tb/tb_move_check_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/move_check_sequencer_if.sv
// Move-request / per-piece-checker / verdict bundle of the move check sequencer.
// The slave modport is the sequencer's view; the master modport is the
// surrounding game-play logic plus the per-piece checkers.
interface move_check_sequencer_if #(
    parameter int NUM_CHECKERS = 6
);
    logic                         req_valid;
    logic                         req_ready;
    logic [2:0]                   old_x;
    logic [2:0]                   old_y;
    logic [2:0]                   new_x;
    logic [2:0]                   new_y;
    logic                         side_to_move;
    logic [7:0][7:0][3:0]         board_in;     // board_in[x][y] = piece code

    logic [NUM_CHECKERS-1:0]      chk_start;
    logic [2:0]                   chk_h_delta;
    logic [2:0]                   chk_v_delta;
    logic [3:0]                   chk_piece_type;
    logic [NUM_CHECKERS-1:0]      chk_done;
    logic [NUM_CHECKERS-1:0]      chk_valid;

    logic                         result_valid;
    logic                         result_ready;
    logic                         move_valid;
    logic [2:0]                   err_code;

    modport slave (
        input  req_valid, old_x, old_y, new_x, new_y, side_to_move, board_in,
        input  chk_done, chk_valid, result_ready,
        output req_ready, chk_start, chk_h_delta, chk_v_delta, chk_piece_type,
        output result_valid, move_valid, err_code
    );

    modport master (
        output req_valid, old_x, old_y, new_x, new_y, side_to_move, board_in,
        output chk_done, chk_valid, result_ready,
        input  req_ready, chk_start, chk_h_delta, chk_v_delta, chk_piece_type,
        input  result_valid, move_valid, err_code
    );
endinterface

// File: rtl/move_check_sequencer.sv
// Front end of the board validator: accepts a move, rejects trivially illegal
// ones, otherwise dispatches to one per-piece checker and waits (with timeout)
// for its verdict, then hands a registered verdict back over valid/ready.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | req_ready=1, waiting for a move request
// PRECHECK  | decode source/destination pieces, register deltas, reject
// DISPATCH  | one-cycle one-hot start pulse to the selected checker
// WAIT      | wait for selected checker done, count towards timeout
// DONE      | result_valid=1, verdict held until result_ready
module move_check_sequencer #(
    parameter int NUM_CHECKERS   = 6,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   CLOCK_50,
    input  logic                   reset_n,
    move_check_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRECHECK = 3'd1,
        S_DISPATCH = 3'd2,
        S_WAIT     = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_EMPTY   = 3'd1;
    localparam logic [2:0] ERR_COLOUR  = 3'd2;
    localparam logic [2:0] ERR_OWN_CAP = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_BAD_PC  = 3'd5;

    state_t             state_q, state_d;
    logic [2:0]         old_x_q, old_y_q, new_x_q, new_y_q;
    logic               side_q;
    logic [3:0]         piece_q;
    logic [2:0]         h_delta_q, v_delta_q;
    logic [2:0]         sel_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               move_valid_q;
    logic [2:0]         err_q;

    logic [3:0]         src, dst;
    logic [2:0]         pre_err;
    logic [2:0]         h_abs, v_abs;
    logic               sel_done, sel_valid, terminal;

    // Source/destination decode and the trivial-rejection checks, in priority order
    always_comb begin
        src     = bus.board_in[old_x_q][old_y_q];
        dst     = bus.board_in[new_x_q][new_y_q];
        h_abs   = (new_x_q > old_x_q) ? (new_x_q - old_x_q) : (old_x_q - new_x_q);
        v_abs   = (new_y_q > old_y_q) ? (new_y_q - old_y_q) : (old_y_q - new_y_q);
        pre_err = ERR_NONE;
        if (src == 4'b0000)
            pre_err = ERR_EMPTY;
        else if (src[2:0] == 3'd7 || src == 4'b1000)
            pre_err = ERR_BAD_PC;
        else if (src[3] != side_q)
            pre_err = ERR_COLOUR;
        else if (dst[2:0] != 3'd0 && dst[3] == src[3])
            pre_err = ERR_OWN_CAP;   // also catches old == new
    end

    // Only the dispatched checker's done/valid are observed
    always_comb begin
        sel_done  = bus.chk_done[sel_q];
        sel_valid = bus.chk_valid[sel_q];
        terminal  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // State register
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (bus.req_valid) state_d = S_PRECHECK;
            S_PRECHECK: state_d = (pre_err != ERR_NONE) ? S_DONE : S_DISPATCH;
            S_DISPATCH: state_d = S_WAIT;
            S_WAIT:     if (sel_done || terminal) state_d = S_DONE;
            S_DONE:     if (bus.result_ready) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        bus.req_ready    = (state_q == S_IDLE);
        bus.result_valid = (state_q == S_DONE);
        bus.chk_start    = '0;
        if (state_q == S_DISPATCH)
            bus.chk_start = {{(NUM_CHECKERS-1){1'b0}}, 1'b1} << sel_q;
    end

    // Request capture, checker operands, timeout counter and verdict registers
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            old_x_q      <= '0;
            old_y_q      <= '0;
            new_x_q      <= '0;
            new_y_q      <= '0;
            side_q       <= 1'b0;
            piece_q      <= '0;
            h_delta_q    <= '0;
            v_delta_q    <= '0;
            sel_q        <= '0;
            cnt_q        <= '0;
            move_valid_q <= 1'b0;
            err_q        <= ERR_NONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        old_x_q      <= bus.old_x;
                        old_y_q      <= bus.old_y;
                        new_x_q      <= bus.new_x;
                        new_y_q      <= bus.new_y;
                        side_q       <= bus.side_to_move;
                        move_valid_q <= 1'b0;
                        err_q        <= ERR_NONE;
                    end
                end
                S_PRECHECK: begin
                    piece_q   <= src;
                    h_delta_q <= h_abs;
                    v_delta_q <= v_abs;
                    sel_q     <= src[2:0] - 3'd1;
                    if (pre_err != ERR_NONE) begin
                        move_valid_q <= 1'b0;
                        err_q        <= pre_err;
                    end
                end
                // The start-pulse cycle counts as the first elapsed cycle
                S_DISPATCH: cnt_q <= CNT_W'(1);
                S_WAIT: begin
                    if (sel_done) begin
                        move_valid_q <= sel_valid;
                        err_q        <= ERR_NONE;
                    end else if (terminal) begin
                        move_valid_q <= 1'b0;
                        err_q        <= ERR_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.chk_h_delta    = h_delta_q;
    assign bus.chk_v_delta    = v_delta_q;
    assign bus.chk_piece_type = piece_q;
    assign bus.move_valid     = move_valid_q;
    assign bus.err_code       = err_q;
endmodule

// File: tb/tb_move_check_sequencer.sv
// Directed and randomized moves against a rule-level reference model.
module tb_move_check_sequencer;
    localparam int NC = 6;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    move_check_sequencer_if #(.NUM_CHECKERS(NC)) bus();

    move_check_sequencer #(.NUM_CHECKERS(NC), .TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50 (clk),
        .reset_n  (rst_n),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;
    int brd [8][8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rule-level legality pre-screen: returns the error code (0 = goes to a checker)
    function automatic int model_err(input int src, input int dst, input int side);
        if (src == 0)                             return 1;
        if ((src % 8) == 7 || src == 8)           return 5;
        if ((src / 8) != side)                    return 2;
        if ((dst % 8) != 0 && (dst / 8) == (src / 8)) return 3;
        return 0;
    endfunction

    task automatic clear_board();
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                brd[x][y] = 0;
    endtask

    task automatic load_board();
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                bus.board_in[x][y] = 4'(brd[x][y]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_start"},  32'(bus.chk_start), 0);
        chk({tag, "_hd"},     32'(bus.chk_h_delta), 0);
        chk({tag, "_vd"},     32'(bus.chk_v_delta), 0);
        chk({tag, "_pt"},     32'(bus.chk_piece_type), 0);
        chk({tag, "_rv"},     32'(bus.result_valid), 0);
        chk({tag, "_mv"},     32'(bus.move_valid), 0);
        chk({tag, "_err"},    32'(bus.err_code), 0);
        chk({tag, "_rready"}, 32'(bus.req_ready), 1);
    endtask

    // One full transaction. delay: cycles after the start pulse at which the
    // selected checker answers (0 = never). hold: cycles result_ready stays low.
    task automatic run_move(input int ox, input int oy, input int nx, input int ny,
                            input int side, input int delay, input bit verdict,
                            input int hold);
        int src, dst, err, idx, exp_cyc, exp_err, exp_mv, hd, vd;
        int cyc, n_start, start_cyc;
        bit disp, answered, done_sel;
        logic [NC-1:0] start_val, r;

        src  = brd[ox][oy];
        dst  = brd[nx][ny];
        err  = model_err(src, dst, side);
        disp = (err == 0);
        idx  = (src % 8) - 1;
        hd   = (ox > nx) ? ox - nx : nx - ox;
        vd   = (oy > ny) ? oy - ny : ny - oy;
        answered = disp && delay > 0 && delay < TO;
        if (!disp) begin
            exp_cyc = 1; exp_err = err; exp_mv = 0;
        end else if (answered) begin
            exp_cyc = 1 + delay + 1; exp_err = 0; exp_mv = verdict;
        end else begin
            exp_cyc = 1 + TO; exp_err = 4; exp_mv = 0;
        end

        @(negedge clk);
        bus.old_x = 3'(ox); bus.old_y = 3'(oy);
        bus.new_x = 3'(nx); bus.new_y = 3'(ny);
        bus.side_to_move = side[0];
        bus.req_valid = 1'b1;
        chk("req_ready_idle", 32'(bus.req_ready), 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.old_x = 3'($urandom); bus.old_y = 3'($urandom);
        bus.new_x = 3'($urandom); bus.new_y = 3'($urandom);
        bus.side_to_move = 1'($urandom);

        cyc = 0; n_start = 0; start_cyc = -1; start_val = '0;
        while (cyc < 60) begin
            @(posedge clk);
            cyc++;
            #1;
            done_sel = disp && delay > 0 && cyc == 1 + delay;
            r = NC'($urandom);
            if (disp) r[idx] = done_sel;
            bus.chk_done = r;
            r = NC'($urandom);
            if (done_sel) r[idx] = verdict;
            bus.chk_valid = r;
            @(negedge clk);
            if (bus.chk_start != '0) begin
                n_start++;
                start_val = bus.chk_start;
                start_cyc = cyc;
            end
            if (bus.result_valid) break;
        end
        bus.chk_done  = '0;
        bus.chk_valid = '0;

        chk("result_seen", 32'(bus.result_valid), 1);
        chk("latency", 32'(cyc + 1), 32'(exp_cyc + 1));
        chk("start_count", 32'(n_start), disp ? 1 : 0);
        if (disp) begin
            chk("start_onehot", 32'(start_val), 32'(1) << idx);
            chk("start_cycle", 32'(start_cyc), 1);
        end
        chk("err_code", 32'(bus.err_code), 32'(exp_err));
        chk("move_valid", 32'(bus.move_valid), 32'(exp_mv));
        chk("h_delta", 32'(bus.chk_h_delta), 32'(hd));
        chk("v_delta", 32'(bus.chk_v_delta), 32'(vd));
        chk("piece_type", 32'(bus.chk_piece_type), 32'(src));

        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("hold_rv", 32'(bus.result_valid), 1);
            chk("hold_req_ready", 32'(bus.req_ready), 0);
            chk("hold_mv", 32'(bus.move_valid), 32'(exp_mv));
            chk("hold_err", 32'(bus.err_code), 32'(exp_err));
            chk("hold_pt", 32'(bus.chk_piece_type), 32'(src));
        end
        bus.result_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.result_ready = 1'b0;
        bus.req_valid    = 1'b0;
        chk("release_rv", 32'(bus.result_valid), 0);
        chk("release_idle", 32'(bus.req_ready), 1);
    endtask

    initial begin
        int ox, oy, nx, ny, side, d;

        bus.req_valid = 1'b0; bus.result_ready = 1'b0;
        bus.old_x = '0; bus.old_y = '0; bus.new_x = '0; bus.new_y = '0;
        bus.side_to_move = 1'b0;
        bus.chk_done = '0; bus.chk_valid = '0;
        clear_board();
        load_board();

        #2 check_reset_outputs("rst_a");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_b");
        rst_n = 1'b1;

        // White knight (1,0)->(2,2), checker answers the cycle after start
        clear_board(); brd[1][0] = 2; load_board();
        run_move(1, 0, 2, 2, 0, 1, 1'b1, 0);

        // Empty source
        clear_board(); load_board();
        run_move(4, 4, 5, 5, 0, 1, 1'b1, 0);

        // Black rook moved by white
        clear_board(); brd[3][3] = 'hC; load_board();
        run_move(3, 3, 3, 6, 0, 1, 1'b1, 0);

        // White queen onto white pawn
        clear_board(); brd[0][0] = 5; brd[0][3] = 1; load_board();
        run_move(0, 0, 0, 3, 0, 1, 1'b1, 0);

        // Null move
        clear_board(); brd[2][2] = 1; load_board();
        run_move(2, 2, 2, 2, 0, 1, 1'b1, 0);

        // Illegal piece codes 7 and 8
        clear_board(); brd[6][6] = 7; brd[5][1] = 8; load_board();
        run_move(6, 6, 0, 0, 0, 1, 1'b1, 0);
        run_move(5, 1, 0, 0, 1, 1, 1'b1, 0);

        // Checker never answers (strays on other indices) -> timeout
        clear_board(); brd[1][0] = 2; load_board();
        run_move(1, 0, 2, 2, 0, 0, 1'b1, 0);

        // Done in the terminal cycle wins; one cycle later is a timeout
        clear_board(); brd[7][0] = 6; load_board();
        run_move(7, 0, 7, 1, 0, TO - 1, 1'b1, 0);
        run_move(7, 0, 7, 1, 0, TO, 1'b1, 0);

        // Black rook captures white pawn, verdict illegal, consumer stalls 5 cycles
        clear_board(); brd[0][7] = 'hC; brd[0][2] = 1; load_board();
        run_move(0, 7, 0, 2, 1, 3, 1'b0, 5);

        // Reset pulse in the middle of WAIT
        clear_board(); brd[1][0] = 2; load_board();
        @(negedge clk);
        bus.old_x = 3'd1; bus.old_y = 3'd0; bus.new_x = 3'd2; bus.new_y = 3'd2;
        bus.side_to_move = 1'b0;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midwait_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.chk_done  = 6'b000010;
        bus.chk_valid = 6'b000010;
        @(negedge clk);
        chk("late_done_rv", 32'(bus.result_valid), 0);
        chk("late_done_idle", 32'(bus.req_ready), 1);
        @(posedge clk);
        #1;
        bus.chk_done  = '0;
        bus.chk_valid = '0;
        run_move(1, 0, 2, 2, 0, 2, 1'b1, 1);

        // Randomized moves
        for (int t = 0; t < 30; t++) begin
            ox = $urandom_range(0, 7); oy = $urandom_range(0, 7);
            nx = $urandom_range(0, 7); ny = $urandom_range(0, 7);
            side = $urandom_range(0, 1);
            for (int x = 0; x < 8; x++)
                for (int y = 0; y < 8; y++)
                    brd[x][y] = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) brd[nx][ny] = 0;
            if ($urandom_range(0, 3) != 0) brd[ox][oy] = side * 8 + $urandom_range(1, 6);
            load_board();
            d = $urandom_range(0, 19);
            run_move(ox, oy, nx, ny, side, d, 1'($urandom), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
